snes_sram_arbiter: RTL

SRAM bus arbiter for the SNES side of the cartridge CPLD. It sits between the SRAM pins and the two SRAM masters: the AVR path (serial address register plus data bus FSM) and the SNES cartridge bus. It hands the SRAM over cleanly when the AVR requests SNES mode, then serves SNES read cycles: it maps the SNES address into SRAM address space, strobes the SRAM, latches the data and drives it onto `snes_data`.

---
 rtl/snes_sram_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/snes_sram_arbiter.sv
// SRAM bus arbiter: hands the cartridge SRAM from the AVR path to the SNES
// bus and serves SNES read cycles with synchronised strobes.
module snes_sram_arbiter #(
    parameter int MAP_MODE    = 0,
    parameter int WAIT_CYCLES = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        snes_mode,
    input  logic [20:0] avr_sram_addr,
    input  logic        avr_oe_n,
    input  logic        avr_we_n,
    input  logic [20:0] snes_addr,
    input  logic        snes_rd_n,
    input  logic [7:0]  sram_din,
    output logic [20:0] sram_addr,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ce_n,
    output logic [7:0]  snes_data,
    output logic        snes_data_oe,
    output logic        mode_ack
);

    typedef enum logic [2:0] {
        AVR, DRAIN, SNES_IDLE, SNES_READ, SNES_HOLD, RELEASE
    } state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t                 state;
    logic [SYNC_STAGES-1:0] mode_sync;
    logic [SYNC_STAGES-1:0] rd_sync;
    logic                   mode_s;
    logic                   rd_s;
    logic                   rd_d;
    logic                   rd_fall;
    logic [20:0]            addr_q;
    logic [20:0]            map_addr;
    logic [3:0]             cnt;
    logic                   oe_q;
    logic                   ce_q;
    logic                   pass;

    assign mode_s  = mode_sync[SYNC_STAGES-1];
    assign rd_s    = rd_sync[SYNC_STAGES-1];
    assign rd_fall = rd_d & ~rd_s;

    always_comb begin
        if (MAP_MODE == 1) map_addr = addr_q;
        else               map_addr = {1'b0, addr_q[20:16], addr_q[14:0]};
    end

    // The AVR owns the pins only outside reset and before the handover.
    assign pass = reset_n & ((state == AVR) | (state == DRAIN));

    assign sram_addr = pass ? avr_sram_addr : map_addr;
    assign sram_oe_n = pass ? avr_oe_n : oe_q;
    assign sram_we_n = pass ? avr_we_n : 1'b1;
    assign sram_ce_n = pass ? (avr_oe_n & avr_we_n) : ce_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= AVR;
            mode_sync    <= '0;
            rd_sync      <= '1;
            rd_d         <= 1'b1;
            addr_q       <= '0;
            cnt          <= '0;
            oe_q         <= 1'b1;
            ce_q         <= 1'b1;
            snes_data    <= '0;
            snes_data_oe <= 1'b0;
            mode_ack     <= 1'b0;
        end else begin
            mode_sync <= {mode_sync[SYNC_STAGES-2:0], snes_mode};
            rd_sync   <= {rd_sync[SYNC_STAGES-2:0], snes_rd_n};
            rd_d      <= rd_s;
            unique case (state)
                AVR: begin
                    if (mode_s) state <= DRAIN;
                end
                DRAIN: begin
                    if (!mode_s) begin
                        state <= AVR;
                    end else if (avr_oe_n && avr_we_n) begin
                        state    <= SNES_IDLE;
                        mode_ack <= 1'b1;
                    end
                end
                SNES_IDLE: begin
                    // A pending read takes priority over a mode drop.
                    if (rd_fall) begin
                        state  <= SNES_READ;
                        addr_q <= snes_addr;
                        oe_q   <= 1'b0;
                        ce_q   <= 1'b0;
                        cnt    <= '0;
                    end else if (!mode_s) begin
                        state    <= RELEASE;
                        mode_ack <= 1'b0;
                    end
                end
                SNES_READ: begin
                    if (rd_s) begin
                        state <= SNES_IDLE;
                        oe_q  <= 1'b1;
                        ce_q  <= 1'b1;
                    end else if (cnt == LAST) begin
                        state        <= SNES_HOLD;
                        snes_data    <= sram_din;
                        snes_data_oe <= 1'b1;
                        oe_q         <= 1'b1;
                        ce_q         <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SNES_HOLD: begin
                    if (rd_s) begin
                        state        <= SNES_IDLE;
                        snes_data_oe <= 1'b0;
                    end
                end
                RELEASE: begin
                    state <= AVR;
                end
                default: begin
                    state <= AVR;
                end
            endcase
        end
    end

endmodule
